// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin front end for the single-port data memory
// Each grant takes one ACCESS cycle, then one RESP cycle carries rvalid, rdata and err.
module dmem_arbiter #(
    parameter int MEM_BYTES = 101,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [2:0]        r0_size,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [2:0]        r1_size,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_rd_wr,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam logic [2:0] LB_SB = 3'b000, LH_SH = 3'b001, LW_SW = 3'b010, LBU = 3'b100, LHU = 3'b101;
    localparam int AW1 = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t         state;
    logic           last_grant, port, we;
    logic           access, win1, arb, half, word, size_ok, align_ok, range_ok, legal;
    logic [2:0]     nbytes;
    logic [AW1-1:0] last_byte;

    always_comb begin
        access    = state == ACCESS;
        win1      = r1_req && (!r0_req || !last_grant);
        arb       = !access && (r0_req || r1_req);
        r0_gnt    = arb && !win1;
        r1_gnt    = arb && win1;
        half      = mem_rd_wr[1:0] == 2'b01;
        word      = mem_rd_wr[1:0] == 2'b10;
        nbytes    = word ? 3'd4 : half ? 3'd2 : 3'd1;
        size_ok   = mem_rd_wr inside {LB_SB, LH_SH, LW_SW, LBU, LHU};
        align_ok  = !(half && mem_addr[0]) && !(word && mem_addr[1:0] != 2'b00);
        // one extra bit so an access near the top of the address space cannot wrap
        last_byte = {1'b0, mem_addr} + AW1'(nbytes - 3'd1);
        range_ok  = last_byte < AW1'(MEM_BYTES);
        legal     = size_ok && align_ok && range_ok && !(we && mem_addr == '0);
        mem_wr    = access && we && legal;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            port       <= 1'b0;
            we         <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_rd_wr  <= LB_SB;
            r0_rvalid  <= 1'b0;
            r0_err     <= 1'b0;
            r0_rdata   <= '0;
            r1_rvalid  <= 1'b0;
            r1_err     <= 1'b0;
            r1_rdata   <= '0;
        end else begin
            r0_rvalid <= access && !port;
            r1_rvalid <= access && port;
            r0_err    <= access && !port && !legal;
            r1_err    <= access && port && !legal;
            r0_rdata  <= (access && !port && legal && !we) ? mem_rdata : '0;
            r1_rdata  <= (access && port && legal && !we) ? mem_rdata : '0;
            if (arb) begin
                state      <= ACCESS;
                port       <= win1;
                last_grant <= win1;
                we         <= win1 ? r1_we : r0_we;
                mem_addr   <= win1 ? r1_addr : r0_addr;
                mem_wdata  <= win1 ? r1_wdata : r0_wdata;
                mem_rd_wr  <= win1 ? r1_size : r0_size;
            end else begin
                state <= access ? RESP : IDLE;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed bench for dmem_arbiter
// A transaction-level reference (byte array, grant order, 2-cycle pipeline) predicts every cycle.
module tb_dmem_arbiter;
    localparam int MB = 101;
    localparam logic [2:0] LB_SB = 3'd0, LH_SH = 3'd1, LW_SW = 3'd2, LBU = 3'd4, LHU = 3'd5;

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        r0_req, r0_we, r0_gnt, r0_rvalid, r0_err;
    logic [2:0]  r0_size;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;
    logic        r1_req, r1_we, r1_gnt, r1_rvalid, r1_err;
    logic [2:0]  r1_size;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_rd_wr;
    logic        mem_wr;

    logic [7:0]  phys [MB];
    logic [7:0]  ref_m [MB];
    bit          ph_init;
    req_t        pq0[$], pq1[$];
    bit          act0, act1, eager, chk_en;
    int          n_chk, n_pass, n_err;
    logic [31:0] cap0, cap1;
    bit          last, acc_v, acc_p, acc_e, acc_wr, resp_v, resp_p, resp_e;
    logic [31:0] acc_d, resp_d;
    bit          glog[$];

    dmem_arbiter #(.MEM_BYTES(MB), .ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_size(r0_size), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_size(r1_size), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_wr(mem_rd_wr), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    function automatic int nbytes(input logic [2:0] s);
        return (s == LB_SB || s == LBU) ? 1 : (s == LH_SH || s == LHU) ? 2 : (s == LW_SW) ? 4 : 0;
    endfunction

    function automatic logic [31:0] ext(input logic [31:0] v, input logic [2:0] s);
        return s == LB_SB ? {{24{v[7]}}, v[7:0]} : s == LH_SH ? {{16{v[15]}}, v[15:0]} : v;
    endfunction

    // memory the DUT talks to: stores commit on the negedge, reads sign/zero extend by size code
    always @(negedge clock) begin
        int n;
        logic [31:0] v;
        if (!ph_init) begin
            for (int i = 0; i < MB; i++) phys[i] = 8'($urandom);
            ph_init = 1'b1;
        end
        n = nbytes(mem_rd_wr) == 0 ? 4 : nbytes(mem_rd_wr);
        if (mem_wr === 1'b1 && mem_addr != 0)
            for (int i = 0; i < n; i++)
                if (64'(mem_addr) + 64'(i) < 64'(MB)) phys[mem_addr + i] = mem_wdata[8*i +: 8];
        v = '0;
        for (int i = 0; i < n; i++)
            if (64'(mem_addr) + 64'(i) < 64'(MB)) v[8*i +: 8] = phys[mem_addr + i];
        mem_rdata = ext(v, mem_rd_wr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit legal(input logic we, input logic [2:0] s, input logic [31:0] a);
        int nb = nbytes(s);
        return nb != 0 && (a % nb) == 0 && 64'(a) + 64'(nb) <= 64'(MB) && !(we && a == 0);
    endfunction

    task automatic model_step();
        bit w, lg;
        logic [1:0] eg;
        logic we;
        logic [2:0] s;
        logic [31:0] a, d, v;
        w  = (r0_req && r1_req) ? !last : r1_req;
        eg = (!acc_v && (r0_req || r1_req)) ? (w ? 2'b10 : 2'b01) : 2'b00;
        check("gnt", {30'd0, r1_gnt, r0_gnt}, {30'd0, eg});
        check("mem_wr", {31'd0, mem_wr}, {31'd0, acc_v && acc_wr});
        check("rvalid", {30'd0, r1_rvalid, r0_rvalid}, resp_v ? (resp_p ? 32'd2 : 32'd1) : 32'd0);
        check("err", {30'd0, r1_err, r0_err}, (resp_v && resp_e) ? (resp_p ? 32'd2 : 32'd1) : 32'd0);
        check("rdata0", r0_rdata, (resp_v && !resp_p) ? resp_d : 32'd0);
        check("rdata1", r1_rdata, (resp_v && resp_p) ? resp_d : 32'd0);
        if (r0_rvalid) begin cap0 = r0_rdata; n_err += int'(r0_err); end
        if (r1_rvalid) begin cap1 = r1_rdata; n_err += int'(r1_err); end
        if (!reset) begin
            acc_v = 0; resp_v = 0; last = 1;
        end else begin
            resp_v = acc_v; resp_p = acc_p; resp_e = acc_e; resp_d = acc_d;
            acc_v = eg != 0;
            if (acc_v) begin
                acc_p = w; last = w; glog.push_back(w);
                we = w ? r1_we : r0_we;
                s  = w ? r1_size : r0_size;
                a  = w ? r1_addr : r0_addr;
                d  = w ? r1_wdata : r0_wdata;
                lg = legal(we, s, a);
                acc_e = !lg; acc_wr = we && lg;
                v = '0;
                if (lg) for (int i = 0; i < nbytes(s); i++)
                    if (we) ref_m[a + i] = d[8*i +: 8]; else v[8*i +: 8] = ref_m[a + i];
                acc_d = (lg && !we) ? ext(v, s) : 32'd0;
            end
        end
    endtask

    task automatic cycle();
        logic [1:0] g;
        @(negedge clock);
        g = {r1_gnt, r0_gnt};
        if (chk_en) model_step();
        @(posedge clock);
        #1;
        if (g[0] === 1'b1 && pq0.size() > 0) begin pq0.delete(0); act0 = 0; end
        if (g[1] === 1'b1 && pq1.size() > 0) begin pq1.delete(0); act1 = 0; end
        if (!act0 && pq0.size() > 0 && (eager || $urandom_range(1) == 1)) act0 = 1;
        if (!act1 && pq1.size() > 0 && (eager || $urandom_range(1) == 1)) act1 = 1;
        r0_req = act0;
        r1_req = act1;
        if (act0) begin r0_we = pq0[0].we; r0_size = pq0[0].size; r0_addr = pq0[0].addr; r0_wdata = pq0[0].wdata; end
        if (act1) begin r1_we = pq1[0].we; r1_size = pq1[0].size; r1_addr = pq1[0].addr; r1_wdata = pq1[0].wdata; end
    endtask

    task automatic push(input int p, input req_t r);
        if (p == 0) pq0.push_back(r); else pq1.push_back(r);
    endtask

    function automatic req_t rnd_req();
        req_t r;
        logic [2:0] codes [8] = '{LB_SB, LH_SH, LW_SW, LBU, LHU, 3'd3, 3'd6, 3'd7};
        int k = int'($urandom_range(9));
        r.size  = k < 8 ? codes[k % 5] : codes[5 + k % 3];
        r.we    = 1'($urandom_range(1));
        r.addr  = ($urandom_range(15) == 0) ? 32'hFFFF_FFF0 + $urandom_range(15) : $urandom_range(MB + 3);
        r.wdata = $urandom;
        return r;
    endfunction

    task automatic drain(input int lim);
        int k = 0;
        while (pq0.size() + pq1.size() + int'(acc_v) + int'(resp_v) != 0 && k < lim) begin
            cycle();
            k++;
        end
        check("drain", pq0.size() + pq1.size() + int'(acc_v) + int'(resp_v), 0);
    endtask

    task automatic rst_pulse();
        reset = 0;
        cycle();
        cycle();
        reset = 1;
    endtask

    initial begin
        int e, base, k;
        {r0_req, r0_we, r0_size, r0_addr, r0_wdata} = '0;
        {r1_req, r1_we, r1_size, r1_addr, r1_wdata} = '0;
        eager = 1; last = 1;
        repeat (3) cycle();
        check("rst_gnt", {30'd0, r1_gnt, r0_gnt}, 0);
        check("rst_rvalid", {30'd0, r1_rvalid, r0_rvalid}, 0);
        check("rst_err", {30'd0, r1_err, r0_err}, 0);
        check("rst_mem_wr", {31'd0, mem_wr}, 0);
        check("rst_rdata", r0_rdata | r1_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_rd_wr", {29'd0, mem_rd_wr}, {29'd0, LB_SB});
        for (int i = 0; i < MB; i++) ref_m[i] = phys[i];
        chk_en = 1;
        reset = 1;

        push(0, '{1'b1, LW_SW, 32'd4, 32'hDEADBEEF});
        drain(50);
        push(0, '{1'b0, LW_SW, 32'd4, 32'd0});
        drain(50);
        check("t1_load", cap0, 32'hDEADBEEF);

        push(0, '{1'b1, LB_SB, 32'd9, 32'h0000_0080});
        push(0, '{1'b0, LB_SB, 32'd9, 32'd0});
        drain(50);
        check("t2_lb", cap0, 32'hFFFF_FF80);
        push(0, '{1'b0, LBU, 32'd9, 32'd0});
        drain(50);
        check("t2_lbu", cap0, 32'h0000_0080);

        e = n_err;
        push(0, '{1'b0, LW_SW, 32'd2, 32'd0});
        push(0, '{1'b0, LH_SH, 32'd5, 32'd0});
        push(0, '{1'b0, LW_SW, 32'd98, 32'd0});
        push(0, '{1'b1, LB_SB, 32'd0, 32'h55});
        drain(100);
        check("t4_errs", n_err - e, 4);

        e = n_err;
        push(1, '{1'b0, LH_SH, 32'hFFFF_FFFE, 32'd0});
        push(1, '{1'b0, 3'd7, 32'd8, 32'd0});
        drain(100);
        check("t5_errs", n_err - e, 2);

        rst_pulse();
        base = glog.size();
        for (int i = 0; i < 8; i++) begin
            push(0, rnd_req());
            push(1, rnd_req());
        end
        drain(200);
        for (int i = 0; i < 16; i++)
            check("t3_alt", glog.size() > base + i ? 32'(glog[base + i]) : 32'hFF, 32'(i % 2));

        push(1, '{1'b0, LW_SW, 32'd4, 32'd0});
        k = 0;
        do begin cycle(); k++; end while (!acc_v && k < 50);
        check("t6_access", {31'd0, acc_v && acc_p}, 1);
        reset = 0;
        cycle();
        reset = 1;
        base = glog.size();
        push(0, '{1'b0, LW_SW, 32'd8, 32'd0});
        push(1, '{1'b0, LW_SW, 32'd12, 32'd0});
        drain(50);
        check("t6_tie", glog.size() > base ? 32'(glog[base]) : 32'hFF, 0);

        eager = 0;
        for (int i = 0; i < 150; i++) begin
            push(0, rnd_req());
            push(1, rnd_req());
        end
        drain(4000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
